sum_pipe: RTL and testbench

SUM_PIPE -- requirements
Module: sum_pipe

---
 rtl/sum_pipe_if.sv | 25 ++
 rtl/sum_pipe.sv | 84 ++++++++
 tb/tb_sum_pipe.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sum_pipe_if.sv
// Operand/result handshake bundle for sum_pipe.
// The producer/consumer side uses the master modport and the pipeline uses the slave modport.
interface sum_pipe_if #(
  parameter int unsigned W = 10
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         flag;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y, flag
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y, flag
  );
endinterface

// File: rtl/sum_pipe.sv
// Wrap/saturating add-subtract pipeline with valid/ready flow control.
// The result is formed in stage 1, and later stages only delay {valid, y, flag}.
module sum_pipe #(
  parameter int unsigned W      = 10,
  parameter int unsigned STAGES = 3
) (
  input  logic        clk,
  input  logic        rst,
  sum_pipe_if.slave   bus,
  output logic        busy,
  output logic [15:0] out_count
);

  logic [STAGES-1:0] stg_v;
  logic [W-1:0]      stg_y [STAGES];
  logic [STAGES-1:0] stg_f;

  logic         advance;
  logic         accept;
  logic [W:0]   sum;
  logic [W:0]   diff;
  logic [W-1:0] res_y;
  logic         res_f;

  assign advance       = !stg_v[STAGES-1] || bus.out_ready;
  assign accept        = bus.in_valid && advance;
  assign bus.in_ready  = advance;
  assign bus.out_valid = stg_v[STAGES-1];
  assign bus.y         = stg_y[STAGES-1];
  assign bus.flag      = stg_f[STAGES-1];
  assign busy          = |stg_v;

  // Bit W of the zero-extended difference is the borrow, which means a < b.
  always_comb begin
    sum   = {1'b0, bus.a} + {1'b0, bus.b};
    diff  = {1'b0, bus.a} - {1'b0, bus.b};
    res_y = sum[W-1:0];
    res_f = sum[W];
    case (bus.op)
      2'b00: begin
        res_y = sum[W-1:0];
        res_f = sum[W];
      end
      2'b01: begin
        res_y = diff[W-1:0];
        res_f = diff[W];
      end
      2'b10: begin
        res_y = sum[W] ? '1 : sum[W-1:0];
        res_f = sum[W];
      end
      default: begin
        res_y = diff[W] ? '0 : diff[W-1:0];
        res_f = diff[W];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_v     <= '0;
      stg_f     <= '0;
      out_count <= '0;
      for (int unsigned i = 0; i < STAGES; i++) begin
        stg_y[i] <= '0;
      end
    end else begin
      if (advance) begin
        stg_v[0] <= accept;
        stg_y[0] <= res_y;
        stg_f[0] <= res_f;
        for (int unsigned i = 1; i < STAGES; i++) begin
          stg_v[i] <= stg_v[i-1];
          stg_y[i] <= stg_y[i-1];
          stg_f[i] <= stg_f[i-1];
        end
      end
      if (stg_v[STAGES-1] && bus.out_ready) begin
        out_count <= out_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sum_pipe.sv
// Directed bench for sum_pipe (W=10, STAGES=3): vector table, backpressure,
// mid-operation reset and output counter wrap.
module tb_sum_pipe;
  localparam int unsigned W = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] out_count;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt;

  sum_pipe_if #(.W(W)) bus ();

  sum_pipe #(.W(W), .STAGES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         f;
  } vec_t;

  typedef struct {
    logic [W-1:0] y;
    logic         f;
  } res_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t model(input logic [1:0] op, input int a, input int b);
    res_t r;
    int   s;
    case (op)
      2'd0: begin s = a + b; r.y = W'(s % 1024); r.f = (s > 1023); end
      2'd1: begin s = a - b; r.y = W'((s + 1024) % 1024); r.f = (a < b); end
      2'd2: begin s = a + b; r.y = (s > 1023) ? W'(1023) : W'(s); r.f = (s > 1023); end
      default: begin r.y = (a < b) ? W'(0) : W'(a - b); r.f = (a < b); end
    endcase
    return r;
  endfunction

  // One isolated operand set: accept, then observe 3-cycle latency, then transfer.
  task automatic run_vec(input vec_t v, input string tag);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op = v.op; bus.a = v.a; bus.b = v.b;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.op = 2'd0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ov_early1"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_ov_early2"}, 32'(bus.out_valid), 32'd0);
    tick();
    chk({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_y"}, 32'(bus.y), 32'(v.y));
    chk({tag, "_flag"}, 32'(bus.flag), 32'(v.f));
    tick();
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, "_cnt"}, 32'(out_count), 32'(exp_cnt));
    chk({tag, "_ov_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{op: 2'd0, a: 10'd1000, b: 10'd100,  y: 10'd76,   f: 1'b1};
    vecs[1]  = '{op: 2'd1, a: 10'd5,    b: 10'd7,    y: 10'd1022, f: 1'b1};
    vecs[2]  = '{op: 2'd1, a: 10'd7,    b: 10'd5,    y: 10'd2,    f: 1'b0};
    vecs[3]  = '{op: 2'd2, a: 10'd1000, b: 10'd100,  y: 10'd1023, f: 1'b1};
    vecs[4]  = '{op: 2'd3, a: 10'd5,    b: 10'd7,    y: 10'd0,    f: 1'b1};
    vecs[5]  = '{op: 2'd2, a: 10'd3,    b: 10'd4,    y: 10'd7,    f: 1'b0};
    vecs[6]  = '{op: 2'd0, a: 10'd3,    b: 10'd4,    y: 10'd7,    f: 1'b0};
    vecs[7]  = '{op: 2'd0, a: 10'd1023, b: 10'd1,    y: 10'd0,    f: 1'b1};
    vecs[8]  = '{op: 2'd3, a: 10'd5,    b: 10'd5,    y: 10'd0,    f: 1'b0};
    vecs[9]  = '{op: 2'd2, a: 10'd1023, b: 10'd0,    y: 10'd1023, f: 1'b0};
    vecs[10] = '{op: 2'd1, a: 10'd0,    b: 10'd1,    y: 10'd1023, f: 1'b1};
    vecs[11] = '{op: 2'd3, a: 10'd900,  b: 10'd123,  y: 10'd777,  f: 1'b0};

    // Reset state, with an offer held during reset that must not be taken.
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.op = 2'd0; bus.a = 10'd1; bus.b = 10'd2;
    bus.out_ready = 1'b1;
    exp_cnt = '0;
    tick(); tick(); tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_flag", 32'(bus.flag), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_no_accept", 32'(bus.out_valid | busy), 32'd0);
    end

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset with two entries in flight.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.op = 2'd0; bus.a = 10'd11; bus.b = 10'd22;
    tick();
    bus.a = 10'd33;
    tick();
    bus.in_valid = 1'b0;
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_count", 32'(out_count), 32'd0);
    tick();
    rst = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_no_stale", 32'(bus.out_valid), 32'd0);
    end
    run_vec(vecs[0], "mid_next");

    // Backpressure: 5 back-to-back sets, consumer stalls in cycles 3..7.
    rst = 1'b1; tick(); rst = 1'b0;
    begin
      res_t         q[$];
      res_t         r;
      int           issued = 0;
      int           cyc = 0;
      logic         stalled = 1'b0;
      logic [W-1:0] held_y = '0;
      logic         held_f = 1'b0;
      int           got_n = 0;
      logic [1:0]   ops [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      int           as  [5] = '{900, 10, 600, 40, 512};
      int           bs  [5] = '{200, 20, 500, 30, 512};
      while ((issued < 5 || q.size() > 0) && cyc < 40) begin
        bus.out_ready = !(cyc >= 3 && cyc <= 7);
        if (issued < 5) begin
          bus.in_valid = 1'b1;
          bus.op = ops[issued]; bus.a = W'(as[issued]); bus.b = W'(bs[issued]);
        end else begin
          bus.in_valid = 1'b0;
        end
        #3;
        if (bus.out_valid && !bus.out_ready)
          chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        if (stalled) begin
          chk("bp_y_stable", 32'(bus.y), 32'(held_y));
          chk("bp_flag_stable", 32'(bus.flag), 32'(held_f));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            chk("bp_unexpected_out", 32'd1, 32'd0);
          end else begin
            r = q.pop_front();
            chk($sformatf("bp_y%0d", got_n), 32'(bus.y), 32'(r.y));
            chk($sformatf("bp_f%0d", got_n), 32'(bus.flag), 32'(r.f));
            got_n++;
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          q.push_back(model(ops[issued], as[issued], bs[issued]));
          issued++;
        end
        stalled = bus.out_valid && !bus.out_ready;
        held_y = bus.y;
        held_f = bus.flag;
        @(posedge clk);
        #1;
        cyc++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      chk("bp_drained", 32'(got_n), 32'd5);
      chk("bp_count", 32'(out_count), 32'd5);
      chk("bp_busy_end", 32'(busy), 32'd0);
    end

    // Counter wrap: 65535 streamed transfers, then one more.
    rst = 1'b1; tick(); rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.op = 2'd0; bus.a = 10'd1; bus.b = 10'd1;
    for (int i = 0; i < 65535; i++) tick();
    bus.in_valid = 1'b0;
    tick(); tick(); tick();
    chk("wrap_pre", 32'(out_count), 32'd65535);
    exp_cnt = 16'hFFFF;
    run_vec(vecs[5], "wrap");
    chk("wrap_zero", 32'(out_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
